// File: rtl/rom.sv
// Microcode decoder ROM: splits an 8-bit instruction into registered
// register-file, ALU, immediate and data-bus nibbles, with a fixed 16x4 constant memory.
module rom (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] instr,
  output logic [3:0] bus,
  output logic [3:0] instr_r,
  output logic [3:0] instr_a,
  output logic [3:0] imm
);

  typedef enum logic [3:0] {
    OP_REG  = 4'h0,
    OP_LDA  = 4'h2,
    OP_JNZ  = 4'h3,
    OP_LDB  = 4'h4,
    OP_LDOP = 4'h6,
    OP_JMP  = 4'h7,
    OP_MOVA = 4'hB,
    OP_MOVR = 4'hF
  } opcode_t;

  typedef enum logic [3:0] {
    R_NOP  = 4'h0,
    R_LDA  = 4'h8,
    R_LDB  = 4'h9,
    R_LDOP = 4'hA,
    R_LDR  = 4'hB,
    R_JMP  = 4'hC,
    R_JNZ  = 4'hD
  } rmop_t;

  logic [3:0] opcode;
  logic [3:0] n;
  logic [3:0] mem_data;
  logic [3:0] bus_d;
  logic [3:0] instr_r_d;
  logic [3:0] instr_a_d;
  logic [3:0] imm_d;

  assign opcode = instr[7:4];
  assign n      = instr[3:0];

  // Constant data memory: MEM[n] = F - n, read-only and independent of reset.
  assign mem_data = 4'hF - n;

  always_comb begin
    bus_d     = '0;
    instr_r_d = R_NOP;
    instr_a_d = '0;
    imm_d     = '0;
    case (opcode)
      OP_REG: begin
        // Operand MSB selects register move (r-field) versus ALU op (a-field).
        if (n[3]) instr_a_d = n;
        else      instr_r_d = n;
      end
      OP_LDA: begin
        instr_r_d = R_LDA;
        imm_d     = n;
        bus_d     = n;
      end
      OP_JNZ: begin
        instr_r_d = R_JNZ;
        imm_d     = n;
        bus_d     = n;
      end
      OP_LDB: begin
        instr_r_d = R_LDB;
        imm_d     = n;
        bus_d     = n;
      end
      OP_LDOP: begin
        instr_r_d = R_LDOP;
        imm_d     = n;
        bus_d     = n;
      end
      OP_JMP: begin
        instr_r_d = R_JMP;
        imm_d     = n;
        bus_d     = n;
      end
      OP_MOVA: begin
        instr_r_d = R_LDA;
        imm_d     = n;
        bus_d     = mem_data;
      end
      OP_MOVR: begin
        instr_r_d = R_LDR;
        imm_d     = n;
        bus_d     = mem_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus     <= '0;
      instr_r <= '0;
      instr_a <= '0;
      imm     <= '0;
    end else begin
      bus     <= bus_d;
      instr_r <= instr_r_d;
      instr_a <= instr_a_d;
      imm     <= imm_d;
    end
  end

endmodule

// File: tb/tb_rom.sv
// Self-checking bench for rom: expected {bus, instr_r, instr_a, imm} words are queued
// when an instruction is driven and compared one cycle later.
module tb_rom;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] instr;
  logic [3:0] bus;
  logic [3:0] instr_r;
  logic [3:0] instr_a;
  logic [3:0] imm;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  rom dut (
    .clk     (clk),
    .rst     (rst),
    .instr   (instr),
    .bus     (bus),
    .instr_r (instr_r),
    .instr_a (instr_a),
    .imm     (imm)
  );

  // Present one instruction for one edge, queue its expectation, then settle past the edge.
  task automatic drive(input logic r, input logic [7:0] i, input logic [15:0] e);
    @(negedge clk);
    rst   = r;
    instr = i;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [15:0] e;
    for (int k = 0; k < 3; k++) begin
      if (k < 2) drive(1'b1, 8'hBA, 16'h0000);
      else       drive(1'b0, 8'hBA, 16'h580A);
      e = sb.pop_front();
      checks++;
      if ({bus, instr_r, instr_a, imm} !== e) begin
        errors++;
        $display("FAIL reset[%0d] got %h required %h", k, {bus, instr_r, instr_a, imm}, e);
      end
    end
  endtask

  task automatic test_regalu;
    logic [7:0]  ins[4] = '{8'h00, 8'h02, 8'h0C, 8'h0F};
    logic [15:0] ex[4]  = '{16'h0000, 16'h0200, 16'h00C0, 16'h00F0};
    logic [15:0] e;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, ins[k], ex[k]);
      e = sb.pop_front();
      checks++;
      if ({bus, instr_r, instr_a, imm} !== e) begin
        errors++;
        $display("FAIL regalu instr=%h got %h required %h", ins[k], {bus, instr_r, instr_a, imm}, e);
      end
    end
    // Whole opcode-0 space: low half is a register move, high half an ALU op.
    for (int n = 0; n < 16; n++) begin
      logic [3:0] nn;
      nn = 4'(n);
      drive(1'b0, {4'h0, nn}, (n < 8) ? {4'h0, nn, 8'h00} : {8'h00, nn, 4'h0});
      e = sb.pop_front();
      checks++;
      if ({bus, instr_r, instr_a, imm} !== e) begin
        errors++;
        $display("FAIL regalu_sweep instr=0%h got %h required %h", nn, {bus, instr_r, instr_a, imm}, e);
      end
    end
  endtask

  task automatic test_immediate;
    logic [7:0]  ins[3] = '{8'h23, 8'h48, 8'h66};
    logic [15:0] ex[3]  = '{16'h3803, 16'h8908, 16'h6A06};
    logic [15:0] e;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, ins[k], ex[k]);
      e = sb.pop_front();
      checks++;
      if ({bus, instr_r, instr_a, imm} !== e) begin
        errors++;
        $display("FAIL immediate instr=%h got %h required %h", ins[k], {bus, instr_r, instr_a, imm}, e);
      end
    end
  endtask

  task automatic test_memory;
    logic [7:0]  ins[4] = '{8'hBA, 8'hF5, 8'hB0, 8'hFF};
    logic [15:0] ex[4]  = '{16'h580A, 16'hAB05, 16'hF800, 16'h0B0F};
    logic [15:0] e;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, ins[k], ex[k]);
      e = sb.pop_front();
      checks++;
      if ({bus, instr_r, instr_a, imm} !== e) begin
        errors++;
        $display("FAIL memory instr=%h got %h required %h", ins[k], {bus, instr_r, instr_a, imm}, e);
      end
    end
    for (int n = 0; n < 16; n++) begin
      logic [3:0] nn;
      logic [3:0] mv;
      nn = 4'(n);
      mv = 4'(15 - n);
      drive(1'b0, {4'hB, nn}, {mv, 4'h8, 4'h0, nn});
      e = sb.pop_front();
      checks++;
      if ({bus, instr_r, instr_a, imm} !== e) begin
        errors++;
        $display("FAIL memory_sweep instr=B%h got %h required %h", nn, {bus, instr_r, instr_a, imm}, e);
      end
    end
  endtask

  task automatic test_jump;
    logic [7:0]  ins[2] = '{8'h38, 8'h76};
    logic [15:0] ex[2]  = '{16'h8D08, 16'h6C06};
    logic [15:0] e;
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, ins[k], ex[k]);
      e = sb.pop_front();
      checks++;
      if ({bus, instr_r, instr_a, imm} !== e) begin
        errors++;
        $display("FAIL jump instr=%h got %h required %h", ins[k], {bus, instr_r, instr_a, imm}, e);
      end
    end
  endtask

  task automatic test_reserved;
    logic [3:0] ops[8] = '{4'h1, 4'h5, 4'h8, 4'h9, 4'hA, 4'hC, 4'hD, 4'hE};
    logic [15:0] e;
    logic [3:0] nn;
    for (int k = 0; k < 8; k++) begin
      for (int r = 0; r < 3; r++) begin
        nn = 4'($urandom_range(15, 0));
        drive(1'b0, {ops[k], nn}, 16'h0000);
        e = sb.pop_front();
        checks++;
        if ({bus, instr_r, instr_a, imm} !== e) begin
          errors++;
          $display("FAIL reserved instr=%h%h got %h required %h", ops[k], nn, {bus, instr_r, instr_a, imm}, e);
        end
      end
    end
  endtask

  task automatic test_back_to_back_reset;
    logic        rs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0]  ins[4] = '{8'h76, 8'h76, 8'h38, 8'hF5};
    logic [15:0] ex[4]  = '{16'h6C06, 16'h0000, 16'h8D08, 16'hAB05};
    logic [15:0] e;
    for (int k = 0; k < 4; k++) begin
      drive(rs[k], ins[k], ex[k]);
      e = sb.pop_front();
      checks++;
      if ({bus, instr_r, instr_a, imm} !== e) begin
        errors++;
        $display("FAIL midreset[%0d] instr=%h got %h required %h", k, ins[k], {bus, instr_r, instr_a, imm}, e);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    instr = 8'hBA;
    test_reset();
    test_regalu();
    test_immediate();
    test_memory();
    test_jump();
    test_reserved();
    test_back_to_back_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
